// File: rtl/instr_mem_loader.sv
// Instruction memory for core_pipeline: programs are streamed in through a valid/ready
// load port, then served combinationally by pc. Optional INSTR_MEM_PARITY_EN adds per-word parity.
module instr_mem_loader #(
    parameter int unsigned       DATA_W   = 14,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       DEPTH    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instraction,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              reload,
`ifdef INSTR_MEM_PARITY_EN
    input  logic              load_par,
    output logic              parity_err,
`endif
    output logic              core_rst_n,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              final_beat;

    assign load_ready  = (state == LOAD);
    assign accept      = load_valid && load_ready;
    assign final_beat  = load_last || (wr_addr == ADDR_W'(DEPTH - 1));
    assign instraction = (state == RUN) ? mem[pc] : NOP_WORD;

    // Storage is deliberately left out of reset so a partial program survives rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LOAD;
            wr_addr      <= '0;
            words_loaded <= '0;
            core_rst_n   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (words_loaded != (ADDR_W + 1)'(DEPTH)) begin
                            words_loaded <= words_loaded + 1'b1;
                        end
                        if (final_beat) begin
                            state      <= RUN;
                            wr_addr    <= '0;
                            core_rst_n <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        state        <= LOAD;
                        wr_addr      <= '0;
                        words_loaded <= '0;
                        core_rst_n   <= 1'b0;
                    end
                end
                default: begin
                    state      <= LOAD;
                    core_rst_n <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (accept) begin
            par[wr_addr] <= load_par;
        end
    end

    // Sticky error: only fetches made while running are judged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (reload) begin
            parity_err <= 1'b0;
        end else if ((state == RUN) && (^{mem[pc], par[pc]})) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader: stimulus pushes expectations from a
// program-level reference model, a negedge monitor pops and compares.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  pc = '0;
    logic [13:0] instraction;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [13:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        reload = 1'b0;
    logic        core_rst_n;
    logic [5:0]  words_loaded;
`ifdef INSTR_MEM_PARITY_EN
    logic        load_par = 1'b0;
    logic        parity_err;
`endif

    always #5 clk = ~clk;

    instr_mem_loader #(.DATA_W(14), .ADDR_W(5), .DEPTH(32), .NOP_WORD(14'h0)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instraction(instraction),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .reload(reload),
`ifdef INSTR_MEM_PARITY_EN
        .load_par(load_par), .parity_err(parity_err),
`endif
        .core_rst_n(core_rst_n), .words_loaded(words_loaded)
    );

    typedef struct {
        int          id;
        logic [13:0] instr;
        logic [5:0]  words;
        logic        crst;
        logic        ready;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   next_id = 0;

    // Reference model: the program image plus where the loader is in the current program.
    logic [13:0] m_mem [32];
    bit          m_run = 0;
    int          m_len = 0;
    bit          par_bad = 0;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (instraction === e.instr && words_loaded === e.words &&
                core_rst_n === e.crst && load_ready === e.ready) begin
                passes++;
            end else begin
                $display("FAIL chk%0d pc=%0d: got instr=%h words=%0d core_rst_n=%b ready=%b, want instr=%h words=%0d core_rst_n=%b ready=%b",
                         e.id, pc, instraction, words_loaded, core_rst_n, load_ready,
                         e.instr, e.words, e.crst, e.ready);
            end
        end
    end

    task automatic expect_at(input logic [4:0] a);
        exp_t e;
        pc      = a;
        e.id    = next_id++;
        e.instr = m_run ? m_mem[a] : 14'h0;
        e.words = 6'(m_len);
        e.crst  = m_run;
        e.ready = !m_run;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] d, input bit last, input bit v);
        load_valid = v;
        load_data  = d;
        load_last  = last;
`ifdef INSTR_MEM_PARITY_EN
        load_par   = (^d) ^ par_bad;
`endif
        @(posedge clk);
        if (v && !m_run) begin
            m_mem[m_len] = d;
            m_len++;
            if (last || m_len == 32) m_run = 1;
        end
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 14'($urandom);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        if (m_run) begin
            m_run = 0;
            m_len = 0;
        end
        #1;
        reload = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = int'($urandom_range(0, 2));
        for (int i = 0; i < n; i++) send(14'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_at(5'd7);
        rst = 1'b1;
        expect_at(5'd0);
        expect_at(5'd17);
        expect_at(5'd31);

        // Full 32-word load, value = address, no load_last.
        for (int i = 0; i < 31; i++) send(14'(i), 1'b0, 1'b1);
        expect_at(5'd3);
        send(14'd31, 1'b0, 1'b1);
        expect_at(5'd5);
        expect_at(5'd31);
        expect_at(5'd0);

        // Writes attempted while running must be ignored.
        send(14'h2222, 1'b1, 1'b1);
        send(14'h1111, 1'b0, 1'b1);
        expect_at(5'd0);
        expect_at(5'd1);

        pulse_reload();
        expect_at(5'd5);

        // Short program with gaps between beats.
        gap(); send(14'h1A2B, 1'b0, 1'b1);
        gap(); send(14'h0001, 1'b0, 1'b1);
        gap(); send(14'h3FFF, 1'b1, 1'b1);
        expect_at(5'd2);
        expect_at(5'd0);
        expect_at(5'd1);
        expect_at(5'd10);

        pulse_reload();
        send(14'h0ABC, 1'b1, 1'b1);
        expect_at(5'd0);
        expect_at(5'd1);

        // reload while still loading must not clear progress.
        pulse_reload();
        for (int i = 0; i < 4; i++) send(14'($urandom), 1'b0, 1'b1);
        pulse_reload();
        expect_at(5'd0);
        send(14'h1234, 1'b1, 1'b1);
        expect_at(5'd4);

        // Randomized programs.
        for (int p = 0; p < 8; p++) begin
            int len;
            pulse_reload();
            len = int'($urandom_range(1, 32));
            for (int i = 0; i < len; i++) begin
                gap();
                if ($urandom_range(0, 7) == 0) pulse_reload();
                send(14'($urandom), (i == len - 1) ? ((len == 32) ? 1'($urandom) : 1'b1) : 1'b0, 1'b1);
            end
            expect_at(5'($urandom));
            send(14'($urandom), 1'($urandom), 1'b1);
            for (int k = 0; k < 3; k++) expect_at(5'($urandom_range(0, len - 1)));
            expect_at(5'($urandom));
        end

        // Asynchronous reset after 10 beats; contents from earlier loads survive.
        pulse_reload();
        for (int i = 0; i < 10; i++) send(14'h0100 + 14'(i), 1'b0, 1'b1);
        #1;
        rst   = 1'b0;
        m_run = 0;
        m_len = 0;
        expect_at(5'd3);
        rst = 1'b1;
        expect_at(5'd3);
        send(14'h2AAA, 1'b1, 1'b1);
        expect_at(5'd0);
        expect_at(5'd5);
        expect_at(5'd20);

`ifdef INSTR_MEM_PARITY_EN
        pulse_reload();
        pc = 5'd0;
        for (int i = 0; i < 4; i++) send(14'($urandom), 1'b0, 1'b1);
        par_bad = 1;
        send(14'h0001, 1'b1, 1'b1);
        par_bad = 0;
        pc = 5'd0;
        @(negedge clk);
        checks++;
        if (parity_err === 1'b0) passes++;
        else $display("FAIL parity_clean: got %b want 0", parity_err);
        @(posedge clk); #1;
        pc = 5'd4;
        @(posedge clk); #1;
        pc = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (parity_err === 1'b1) passes++;
        else $display("FAIL parity_sticky: got %b want 1", parity_err);
        @(posedge clk); #1;
        pulse_reload();
        @(negedge clk);
        checks++;
        if (parity_err === 1'b0) passes++;
        else $display("FAIL parity_clear: got %b want 0", parity_err);
        @(posedge clk); #1;
`endif

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
